// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, named source/destination indices, command type and one-hot helper.
package bus_pkg;
  localparam int NSRC = 24;
  localparam int NDST = 24;
  localparam int IW = 5;
  localparam logic [IW-1:0] SRC_R0 = 5'd0;
  localparam logic [IW-1:0] SRC_R1 = 5'd1;
  localparam logic [IW-1:0] SRC_R2 = 5'd2;
  localparam logic [IW-1:0] SRC_R3 = 5'd3;
  localparam logic [IW-1:0] SRC_R4 = 5'd4;
  localparam logic [IW-1:0] SRC_R5 = 5'd5;
  localparam logic [IW-1:0] SRC_R6 = 5'd6;
  localparam logic [IW-1:0] SRC_R7 = 5'd7;
  localparam logic [IW-1:0] SRC_R8 = 5'd8;
  localparam logic [IW-1:0] SRC_R9 = 5'd9;
  localparam logic [IW-1:0] SRC_R10 = 5'd10;
  localparam logic [IW-1:0] SRC_R11 = 5'd11;
  localparam logic [IW-1:0] SRC_R12 = 5'd12;
  localparam logic [IW-1:0] SRC_R13 = 5'd13;
  localparam logic [IW-1:0] SRC_R14 = 5'd14;
  localparam logic [IW-1:0] SRC_R15 = 5'd15;
  localparam logic [IW-1:0] SRC_HI = 5'd16;
  localparam logic [IW-1:0] SRC_LO = 5'd17;
  localparam logic [IW-1:0] SRC_ZHI = 5'd18;
  localparam logic [IW-1:0] SRC_ZLO = 5'd19;
  localparam logic [IW-1:0] SRC_PC = 5'd20;
  localparam logic [IW-1:0] SRC_MDR = 5'd21;
  localparam logic [IW-1:0] SRC_INPORT = 5'd22;
  localparam logic [IW-1:0] SRC_CSIGN = 5'd23;
  // Destinations share the register numbering of the sources.
  localparam logic [IW-1:0] DST_R0 = 5'd0;
  localparam logic [IW-1:0] DST_R1 = 5'd1;
  localparam logic [IW-1:0] DST_R2 = 5'd2;
  localparam logic [IW-1:0] DST_R3 = 5'd3;
  localparam logic [IW-1:0] DST_R4 = 5'd4;
  localparam logic [IW-1:0] DST_R5 = 5'd5;
  localparam logic [IW-1:0] DST_R6 = 5'd6;
  localparam logic [IW-1:0] DST_R7 = 5'd7;
  localparam logic [IW-1:0] DST_R8 = 5'd8;
  localparam logic [IW-1:0] DST_R9 = 5'd9;
  localparam logic [IW-1:0] DST_R10 = 5'd10;
  localparam logic [IW-1:0] DST_R11 = 5'd11;
  localparam logic [IW-1:0] DST_R12 = 5'd12;
  localparam logic [IW-1:0] DST_R13 = 5'd13;
  localparam logic [IW-1:0] DST_R14 = 5'd14;
  localparam logic [IW-1:0] DST_R15 = 5'd15;
  localparam logic [IW-1:0] DST_HI = 5'd16;
  localparam logic [IW-1:0] DST_LO = 5'd17;
  localparam logic [IW-1:0] DST_Y = 5'd18;
  localparam logic [IW-1:0] DST_Z = 5'd19;
  localparam logic [IW-1:0] DST_PC = 5'd20;
  localparam logic [IW-1:0] DST_MDR = 5'd21;
  localparam logic [IW-1:0] DST_OUTPORT = 5'd22;
  localparam logic [IW-1:0] DST_IR = 5'd23;
  typedef struct packed {
    logic [IW-1:0] src;
    logic [IW-1:0] dst;
  } cmd_t;
  function automatic logic [NSRC-1:0] onehot(input logic [IW-1:0] idx);
    return NSRC'(1) << idx;
  endfunction
endpackage

// File: rtl/xfer_fifo.sv
// xfer_fifo: synchronous command FIFO with occupancy count and asynchronous clear.
module xfer_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 10
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
  end
  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end
  assign level = wr_q - rd_q;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = wr_q == rd_q;
  assign dout = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: queues (src,dst) transfer commands and drives one one-hot bus transfer per cycle.
// Optional BUS_XFER_BYPASS_EN lets a command into an idle, unstalled issue register without queuing.
module bus_xfer_sequencer #(
  parameter int NSRC = bus_pkg::NSRC,
  parameter int NDST = bus_pkg::NDST,
  parameter int DEPTH = 4,
  parameter int IW = bus_pkg::IW
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [IW-1:0]          req_src,
  input  logic [IW-1:0]          req_dst,
  input  logic                   stall,
  output logic [NSRC-1:0]        enc_out,
  output logic [NDST-1:0]        load_out,
  output logic                   busy,
  output logic                   err,
  output logic [$clog2(DEPTH):0] level
);
  import bus_pkg::*;
  logic [NSRC-1:0] enc_q, enc_d;
  logic [NDST-1:0] load_q, load_d;
  logic err_q, err_d;
  logic full, empty, accept, illegal, push, pop, byp;
  logic [2*IW-1:0] head;
  logic [IW-1:0] head_src, head_dst;
  assign req_ready = !full;
  assign accept = req_valid && req_ready;
  assign illegal = int'(req_src) >= NSRC || int'(req_dst) >= NDST;
  assign pop = !stall && !empty;
`ifdef BUS_XFER_BYPASS_EN
  assign byp = accept && !illegal && empty && !stall;
`else
  assign byp = 1'b0;
`endif
  assign push = accept && !illegal && !byp;
  assign {head_src, head_dst} = head;
  always_comb begin
    err_d = accept && illegal;
    enc_d = stall ? enc_q : pop ? NSRC'(1) << head_src : byp ? NSRC'(1) << req_src : '0;
    load_d = stall ? load_q : pop ? NDST'(1) << head_dst : byp ? NDST'(1) << req_dst : '0;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      enc_q <= '0;
      load_q <= '0;
      err_q <= 1'b0;
    end else begin
      enc_q <= enc_d;
      load_q <= load_d;
      err_q <= err_d;
    end
  end
  xfer_fifo #(.DEPTH(DEPTH), .DW(2*IW)) u_fifo (
    .clock(clock),
    .clear(clear),
    .push(push),
    .pop(pop),
    .din({req_src, req_dst}),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  assign enc_out = enc_q;
  assign load_out = load_q;
  assign err = err_q;
  assign busy = level != '0 || enc_q != '0;
endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// tb_bus_xfer_sequencer: directed vector table, asynchronous clear checks and a random run against a queue model.
module tb_bus_xfer_sequencer;
  import bus_pkg::*;
  localparam int DEPTH = 4;
`ifdef BUS_XFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0;
  logic clear, req_valid, req_ready, stall, busy, err;
  logic [4:0] req_src, req_dst;
  logic [23:0] enc_out, load_out;
  logic [2:0] level;
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  bus_xfer_sequencer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .stall(stall), .enc_out(enc_out),
    .load_out(load_out), .busy(busy), .err(err), .level(level)
  );
  cmd_t mq[$];
  cmd_t mcur;
  bit mcur_v, merr;
  typedef struct {
    logic v;
    logic [4:0] s, d;
    logic st;
    logic [23:0] enc, ld;
    logic [2:0] lvl;
    logic rdy, er;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic add(input int v, input int s, input int d, input int st, input int enc,
                     input int ld, input int lvl, input int rdy, input int er);
    vec_t r;
    r.v = 1'(v); r.s = 5'(s); r.d = 5'(d); r.st = 1'(st);
    r.enc = 24'(enc); r.ld = 24'(ld); r.lvl = 3'(lvl); r.rdy = 1'(rdy); r.er = 1'(er);
    tbl.push_back(r);
  endtask
  task automatic model_edge(input logic v, input logic [4:0] s, input logic [4:0] d, input logic st);
    bit acc, ill, byp;
    acc = v && (mq.size() < DEPTH);
    ill = s >= 24 || d >= 24;
    merr = acc && ill;
    byp = BYP && acc && !ill && mq.size() == 0 && !st;
    if (!st) begin
      if (mq.size() != 0) begin
        mcur = mq.pop_front();
        mcur_v = 1'b1;
      end else begin
        mcur = '{src: s, dst: d};
        mcur_v = byp;
      end
    end
    if (acc && !ill && !byp) mq.push_back('{src: s, dst: d});
  endtask
  task automatic model_clear();
    mq.delete();
    mcur_v = 1'b0;
    merr = 1'b0;
  endtask
  task automatic cyc(input logic v, input logic [4:0] s, input logic [4:0] d, input logic st);
    req_valid = v; req_src = s; req_dst = d; stall = st;
    model_edge(v, s, d, st);
    @(posedge clock);
    #1;
  endtask
  task automatic check_model();
    logic [23:0] ee, el;
    ee = mcur_v ? 24'(1) << mcur.src : 24'h0;
    el = mcur_v ? 24'(1) << mcur.dst : 24'h0;
    chk("rand enc_out", 32'(enc_out), 32'(ee));
    chk("rand load_out", 32'(load_out), 32'(el));
    chk("rand level", 32'(level), 32'(mq.size()));
    chk("rand req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
    chk("rand busy", 32'(busy), 32'(mq.size() != 0 || mcur_v));
    chk("rand err", 32'(err), 32'(merr));
  endtask
  task automatic check_cleared(input string tag);
    chk({tag, " enc_out"}, 32'(enc_out), 32'h0);
    chk({tag, " load_out"}, 32'(load_out), 32'h0);
    chk({tag, " level"}, 32'(level), 32'h0);
    chk({tag, " req_ready"}, 32'(req_ready), 32'h1);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " err"}, 32'(err), 32'h0);
  endtask
  initial begin
    logic v, st;
    logic [4:0] s, d;
    clear = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0; stall = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset");
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock);
    #1;
`ifndef BUS_XFER_BYPASS_EN
    // v, src, dst, stall | enc, load, level, ready, err after the edge
    add(1, 5, 20, 0, 'h0, 'h0, 1, 1, 0);
    add(0, 0, 0, 0, 'h20, 'h100000, 0, 1, 0);
    add(0, 0, 0, 0, 'h0, 'h0, 0, 1, 0);
    add(1, 0, 4, 0, 'h0, 'h0, 1, 1, 0);
    add(1, 1, 5, 0, 'h1, 'h10, 1, 1, 0);
    add(1, 2, 6, 0, 'h2, 'h20, 1, 1, 0);
    add(1, 3, 7, 0, 'h4, 'h40, 1, 1, 0);
    add(0, 0, 0, 0, 'h8, 'h80, 0, 1, 0);
    add(0, 0, 0, 0, 'h0, 'h0, 0, 1, 0);
    add(1, 8, 12, 1, 'h0, 'h0, 1, 1, 0);
    add(1, 9, 13, 1, 'h0, 'h0, 2, 1, 0);
    add(1, 10, 14, 1, 'h0, 'h0, 3, 1, 0);
    add(1, 11, 15, 1, 'h0, 'h0, 4, 0, 0);
    add(1, 12, 16, 1, 'h0, 'h0, 4, 0, 0);
    add(1, 12, 16, 0, 'h100, 'h1000, 3, 1, 0);
    add(1, 12, 16, 0, 'h200, 'h2000, 3, 1, 0);
    add(0, 0, 0, 0, 'h400, 'h4000, 2, 1, 0);
    add(0, 0, 0, 0, 'h800, 'h8000, 1, 1, 0);
    add(0, 0, 0, 0, 'h1000, 'h10000, 0, 1, 0);
    add(0, 0, 0, 0, 'h0, 'h0, 0, 1, 0);
    add(1, 24, 3, 0, 'h0, 'h0, 0, 1, 1);
    add(0, 0, 0, 0, 'h0, 'h0, 0, 1, 0);
    add(1, 21, 1, 0, 'h0, 'h0, 1, 1, 0);
    add(1, 2, 2, 0, 'h200000, 'h2, 1, 1, 0);
    add(0, 0, 0, 1, 'h200000, 'h2, 1, 1, 0);
    add(0, 0, 0, 1, 'h200000, 'h2, 1, 1, 0);
    add(0, 0, 0, 1, 'h200000, 'h2, 1, 1, 0);
    add(0, 0, 0, 0, 'h4, 'h4, 0, 1, 0);
    add(0, 0, 0, 0, 'h0, 'h0, 0, 1, 0);
    add(0, 0, 0, 1, 'h0, 'h0, 0, 1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].st);
      chk($sformatf("row%0d enc_out", i), 32'(enc_out), 32'(tbl[i].enc));
      chk($sformatf("row%0d load_out", i), 32'(load_out), 32'(tbl[i].ld));
      chk($sformatf("row%0d level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].er));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].lvl != 0 || tbl[i].enc != 0));
    end
    cyc(1'b1, 5'd1, 5'd2, 1'b0);
    cyc(1'b1, 5'd3, 5'd4, 1'b0);
    cyc(1'b1, 5'd5, 5'd6, 1'b1);
    cyc(1'b1, 5'd7, 5'd8, 1'b1);
    req_valid = 1'b0;
    chk("pre-clear level", 32'(level), 32'h3);
    chk("pre-clear enc_out", 32'(enc_out), 32'h2);
    chk("pre-clear load_out", 32'(load_out), 32'h4);
    #2 clear = 1'b1;
    #1 check_cleared("async clear");
    #1 clear = 1'b0;
    model_clear();
    cyc(1'b0, 5'd0, 5'd0, 1'b0);
    check_model();
`endif
    for (int i = 0; i < 3000; i++) begin
      v = $urandom_range(0, 9) < 7;
      st = $urandom_range(0, 9) < 3;
      s = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      d = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      cyc(v, s, d, st);
      check_model();
      if ($urandom_range(0, 249) == 0) begin
        clear = 1'b1;
        #1 check_cleared("rand clear");
        model_clear();
        #1 clear = 1'b0;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_xfer_sequencer.md
Name: bus_xfer_sequencer

Overview:
- Generates the one-hot bus-drive vector consumed by the datapath bus multiplexer's 24-bit encoder input, plus the matching one-hot destination load enable.
- Control logic enqueues register-transfer commands as (source index, destination index) pairs. The block buffers them and issues exactly one bus transfer per cycle.
- It is the initiator end of the bus-select interface: it produces the one-hot codes that the bus mux decodes.

Parameters:
- NSRC, 24, number of bus sources; drive vector width. Index map: 0-15 R0-R15, 16 HI, 17 LO, 18 Zhi, 19 Zlo, 20 PC, 21 MDR, 22 InPort, 23 C sign-extended.
- NDST, 24, number of load-enable destinations; load vector width.
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- IW, 5, index width; must satisfy 2^IW >= max(NSRC, NDST).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- req_valid  in  1  command present.
- req_ready  out  1  FIFO can accept; equals !full, from registered state only.
- req_src  in  IW  source index.
- req_dst  in  IW  destination index.
- stall  in  1  hold the current transfer (e.g. memory not ready).
- enc_out  out  NSRC  one-hot bus-drive vector to the bus mux encoder input; all-zero when idle.
- load_out  out  NDST  one-hot destination load enable; all-zero when idle.
- busy  out  1  FIFO non-empty or a transfer is on the bus.
- err  out  1  one-cycle pulse: an illegal command was dropped.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (clear high): asynchronous.
  - enc_out=0, load_out=0, err=0, level=0, busy=0, req_ready=1.
  - FIFO pointers zeroed; in-flight commands discarded.
  - Takes effect mid-transfer as well; no partial vector survives.
- Accept: a command is taken at a rising edge when req_valid && req_ready.
- Illegal commands: req_src >= NSRC or req_dst >= NDST.
  - Consumed (handshake completes) but not stored.
  - err=1 for the following cycle only.
- Issue register: holds the current transfer; updated at each edge as follows.
  - stall=1: enc_out/load_out hold their values; FIFO not popped.
  - stall=0 and FIFO non-empty: pop head; enc_out = 1<<src, load_out = 1<<dst.
  - stall=0 and FIFO empty: enc_out=0, load_out=0.
- Latency: a command accepted at edge N drives the bus in the cycle after edge N+1 when the FIFO was empty and stall=0. Each command drives for exactly one cycle, plus one cycle per stalled edge.
- Order: strict FIFO; no reordering and no merging.
- Simultaneous push and pop: level unchanged; both occur.
- Full: req_ready=0; a pop in the same cycle does not raise ready combinationally. Ready rises the cycle after.
- Empty with stall=1 while idle: outputs stay zero.
- src==dst is legal (e.g. R3out/R3in); both vectors assert the same bit position.
- Invariant: enc_out and load_out are each zero or one-hot at all times. They never carry multiple bits, because the bus mux defaults on non-one-hot input.
- busy = (level!=0) || (enc_out!=0).

Optional Feature:
- Macro: BUS_XFER_BYPASS_EN.
- Defined:
  - A legal command accepted at edge N with FIFO empty and stall=0 loads the issue register directly at edge N. It drives the bus in the cycle after edge N, saving one cycle.
  - The FIFO is not written in that case.
  - If the issue register is stalled, the command enters the FIFO as normal.
- Undefined: every command passes through the FIFO, with latency as stated above.

Decomposition:
- Shared package bus_pkg:
  - NSRC, NDST, IW.
  - Named source index constants: SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_INPORT, SRC_CSIGN.
  - Named destination index constants.
  - A typedef for the command struct {src, dst}.
  - A function onehot(idx) returning the NSRC-bit vector.
- One sub-module: xfer_fifo.
  - Synchronous FIFO, parameter DEPTH, data width 2*IW.
  - Provides push/pop/full/empty/level.

Test Plan:
- Reset then a single command: src=SRC_R5(5), dst=SRC_PC-equivalent dst 20.
  - -> enc_out=32'h000020 (24-bit 0x000020) and load_out=0x100000 for exactly one cycle, two edges after accept (one edge with bypass); then both zero; busy falls.
- Four back-to-back commands (src 0,1,2,3; dst 4,5,6,7) with stall=0.
  - -> enc_out sequence 0x000001, 0x000002, 0x000004, 0x000008 on consecutive cycles.
  - -> load_out 0x000010..0x000080 in matching order; level peaks then drains to 0.
- Fill with stall=1: push 4 commands; 5th request.
  - -> req_ready=0 and level=4. Drop stall: one pop per cycle; req_ready returns one cycle after the first pop; 5th command is issued last.
- Illegal command src=24, dst=3.
  - -> handshake completes; err=1 for one cycle; no bus activity; level unchanged.
- Stall mid-transfer: enc_out=0x200000 (MDR) with stall held 3 edges.
  - -> vector held 4 cycles total; next queued entry follows.
- Assert clear while level=3 and enc_out non-zero.
  - -> enc_out=0, load_out=0, level=0, req_ready=1 immediately (asynchronous), with no clock edge needed.
